// File: rtl/word_width_upsizer_if.sv
// rtl/word_width_upsizer_if.sv - narrow input stream and wide output stream bundle for the upsizer
interface word_width_upsizer_if #(
    parameter int IN_W  = 330,
    parameter int OUT_W = 1320,
    parameter int CW    = 3
);
    logic [IN_W-1:0]  din;
    logic             din_valid;
    logic             din_last;
    logic             din_ready;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             dout_last;
    logic [CW-1:0]    dout_beats;
    logic             dout_ready;

    // Environment side: produces narrow beats, consumes wide beats
    modport master (
        output din, din_valid, din_last, dout_ready,
        input  din_ready, dout, dout_valid, dout_last, dout_beats
    );

    // Packer side: consumes narrow beats, produces wide beats
    modport slave (
        input  din, din_valid, din_last, dout_ready,
        output din_ready, dout, dout_valid, dout_last, dout_beats
    );
endinterface

// File: rtl/word_width_upsizer.sv
// rtl/word_width_upsizer.sv - packs RATIO narrow beats into one wide beat with last-flush and stall buffering
module word_width_upsizer #(
    parameter int WORD_LEN = 66,
    parameter int IN_WORDS = 5,
    parameter int RATIO    = 4
) (
    input  logic                  clk,
    input  logic                  srst_n,
    word_width_upsizer_if.slave   io
);
    localparam int IN_W  = IN_WORDS * WORD_LEN;
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = ($clog2(RATIO + 1) > 1) ? $clog2(RATIO + 1) : 1;
    localparam int CNTW  = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [OUT_W-1:0] acc;
    logic [CNTW-1:0]  cnt;
    logic             acc_full;
    logic             acc_last;
    logic [CW-1:0]    acc_beats;

    logic [OUT_W-1:0] dout_r;
    logic             dout_valid_r;
    logic             dout_last_r;
    logic [CW-1:0]    dout_beats_r;

    logic             out_free;
    logic             accept;
    logic             complete;
    logic [CW-1:0]    beats_now;
    logic [OUT_W-1:0] merged;

    assign out_free  = !dout_valid_r || io.dout_ready;
    // Ready comes from registered state only, so it never loops back through din_valid
    assign io.din_ready = !acc_full;
    assign accept    = io.din_valid && !acc_full;
    assign complete  = (cnt == CNTW'(RATIO - 1)) || io.din_last;
    assign beats_now = CW'(cnt) + CW'(1);

    assign io.dout       = dout_r;
    assign io.dout_valid = dout_valid_r;
    assign io.dout_last  = dout_last_r;
    assign io.dout_beats = dout_beats_r;

    // Current accumulator with the incoming beat dropped into its slot
    always_comb begin
        merged = acc;
        merged[int'(cnt) * IN_W +: IN_W] = io.din;
    end

    // Accumulator, slot counter and output register update
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            acc          <= '0;
            cnt          <= '0;
            acc_full     <= 1'b0;
            acc_last     <= 1'b0;
            acc_beats    <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            dout_beats_r <= '0;
        end else begin
            // Drained output with nothing new to load goes idle; data is left as is
            if (dout_valid_r && io.dout_ready) begin
                dout_valid_r <= 1'b0;
            end

            if (acc_full && out_free) begin
                // Parked group moves out; input is blocked this cycle by din_ready
                dout_r       <= acc;
                dout_valid_r <= 1'b1;
                dout_last_r  <= acc_last;
                dout_beats_r <= acc_beats;
                acc          <= '0;
                cnt          <= '0;
                acc_full     <= 1'b0;
            end else if (accept) begin
                if (!complete) begin
                    acc <= merged;
                    cnt <= cnt + CNTW'(1);
                end else if (out_free) begin
                    // Bypass the accumulator straight into the output register
                    dout_r       <= merged;
                    dout_valid_r <= 1'b1;
                    dout_last_r  <= io.din_last;
                    dout_beats_r <= beats_now;
                    acc          <= '0;
                    cnt          <= '0;
                end else begin
                    // Output busy: park the finished group and stop taking input
                    acc       <= merged;
                    acc_full  <= 1'b1;
                    acc_last  <= io.din_last;
                    acc_beats <= beats_now;
                end
            end
        end
    end
endmodule
